hzd_scoreboard: RTL and testbench

- Parametrised scoreboard-based hazard unit that replaces fixed three-stage compare logic.
- Tracks pending register writes with per-register latency countdowns, and stalls issue into execute until every source and destination register is safe to use.
- Supports fixed-latency producers (ALU, load, multiply) and variable-latency producers (divider, memory with wait states) that clear on writeback.
- Sits between the decode/execute boundary and the writeback port.

---
 rtl/hzd_scoreboard.sv | 113 +++++++++++
 tb/tb_hzd_scoreboard.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hzd_scoreboard.sv
// Scoreboard hazard unit: per-register busy/latency tracking that holds issue until operands are safe.
// Optional HZD_STALL_CNT_EN adds a saturating stalled-cycle counter output (stall_cycles).
module hzd_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_SRC  = 2,
    parameter int LAT_W    = 3,
    parameter int REG_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic                     iss_has_rd,
    input  logic [REG_W-1:0]         iss_rd_num,
    input  logic [LAT_W-1:0]         iss_lat,
    input  logic [NUM_SRC-1:0]       iss_src_valid,
    input  logic [NUM_SRC*REG_W-1:0] iss_src_num,
    input  logic                     wb_valid,
    input  logic [REG_W-1:0]         wb_rd_num,
    input  logic                     flush,
    output logic                     stall,
    output logic                     iss_fire,
    output logic [NUM_SRC-1:0]       src_busy
`ifdef HZD_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam logic [LAT_W-1:0] LAT_UNK = '1;
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    logic [NUM_REGS-1:0] r_busy;
    logic [LAT_W-1:0]    r_cnt [NUM_REGS];

    logic [NUM_REGS-1:0] w_hot;
    logic [NUM_SRC-1:0]  w_src_busy;
    logic                w_waw;
    logic                w_hazard;
    logic                w_fire;
    logic                w_set_rd;
    logic [REG_W-1:0]    w_src_num;

    // An entry in its last countdown cycle is forwardable, so it no longer blocks issue.
    always_comb begin
        w_hot = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_hot[r] = r_busy[r] && (r_cnt[r] != LAT_ONE);
        end
    end

    always_comb begin
        w_src_busy = '0;
        w_src_num  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src_num = iss_src_num[i*REG_W +: REG_W];
            if (iss_valid && iss_src_valid[i] && (w_src_num != '0) && w_hot[w_src_num]) begin
                w_src_busy[i] = 1'b1;
            end
        end
    end

    assign w_waw    = iss_valid && iss_has_rd && (iss_rd_num != '0) && w_hot[iss_rd_num];
    assign w_hazard = (|w_src_busy) || w_waw;
    assign w_fire   = !rst && iss_valid && !w_hazard && !flush;
    assign w_set_rd = w_fire && iss_has_rd && (iss_rd_num != '0) && (iss_lat != '0);

    assign stall    = rst || w_hazard;
    assign iss_fire = w_fire;
    assign src_busy = rst ? '0 : w_src_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_set_rd && (iss_rd_num == REG_W'(r))) begin
                    r_busy[r] <= 1'b1;
                    r_cnt[r]  <= iss_lat;
                end else if (r_busy[r]) begin
                    if (r_cnt[r] == LAT_UNK) begin
                        if (wb_valid && (wb_rd_num == REG_W'(r))) begin
                            r_busy[r] <= 1'b0;
                        end
                    end else if (r_cnt[r] == LAT_ONE) begin
                        r_busy[r] <= 1'b0;
                    end else begin
                        r_cnt[r] <= r_cnt[r] - LAT_ONE;
                    end
                end
            end
        end
    end

`ifdef HZD_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (iss_valid && w_hazard && !flush && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hzd_scoreboard.sv
// Bench for hzd_scoreboard: per-register "ready cycle" reference model plus directed and random stimulus.
module tb_hzd_scoreboard;
    localparam int NR = 32;
    localparam int NS = 2;
    localparam int LW = 3;
    localparam int RW = 5;
    localparam longint INF = 64'h7FFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             iss_valid;
    logic             iss_has_rd;
    logic [RW-1:0]    iss_rd_num;
    logic [LW-1:0]    iss_lat;
    logic [NS-1:0]    iss_src_valid;
    logic [NS*RW-1:0] iss_src_num;
    logic             wb_valid;
    logic [RW-1:0]    wb_rd_num;
    logic             flush;
    logic             stall;
    logic             iss_fire;
    logic [NS-1:0]    src_busy;
`ifdef HZD_STALL_CNT_EN
    logic [31:0]      stall_cycles;
`endif

    hzd_scoreboard #(.NUM_REGS(NR), .NUM_SRC(NS), .LAT_W(LW)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_has_rd(iss_has_rd), .iss_rd_num(iss_rd_num),
        .iss_lat(iss_lat), .iss_src_valid(iss_src_valid), .iss_src_num(iss_src_num),
        .wb_valid(wb_valid), .wb_rd_num(wb_rd_num), .flush(flush),
        .stall(stall), .iss_fire(iss_fire), .src_busy(src_busy)
`ifdef HZD_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Model: register r may be consumed in any cycle >= ready_at[r]; INF means waiting for writeback.
    longint ready_at [NR];
    longint cyc = 0;
    longint m_stall_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_hot(input logic [RW-1:0] r);
        return (r != 0) && (cyc < ready_at[r]);
    endfunction

    task automatic set_iss(input bit v, input bit hr, input int rd, input int lat,
                           input int sv, input int s0, input int s1);
        iss_valid     = v;
        iss_has_rd    = hr;
        iss_rd_num    = RW'(rd);
        iss_lat       = LW'(lat);
        iss_src_valid = NS'(sv);
        iss_src_num   = {RW'(s1), RW'(s0)};
    endtask

    task automatic idle();
        set_iss(0, 0, 0, 0, 0, 0, 0);
        wb_valid  = 1'b0;
        wb_rd_num = '0;
        flush     = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; compares, then advances one clock.
    task automatic step(input int e_stall = -1, input int e_fire = -1, input int e_sb = -1);
        logic [NS-1:0] sb;
        logic          waw, st, fi;
        #1;
        sb = '0;
        for (int i = 0; i < NS; i++) begin
            if (iss_valid && iss_src_valid[i] && m_hot(iss_src_num[i*RW +: RW])) sb[i] = 1'b1;
        end
        waw = iss_valid && iss_has_rd && m_hot(iss_rd_num);
        if (rst) begin
            st = 1'b1; fi = 1'b0; sb = '0;
        end else begin
            st = (|sb) || waw;
            fi = iss_valid && !st && !flush;
        end
        chk("stall", longint'(stall), longint'(st));
        chk("iss_fire", longint'(iss_fire), longint'(fi));
        chk("src_busy", longint'(src_busy), longint'(sb));
`ifdef HZD_STALL_CNT_EN
        chk("stall_cycles", longint'(stall_cycles), m_stall_cnt);
`endif
        if (e_stall >= 0) chk("lit_stall", longint'(stall), longint'(e_stall));
        if (e_fire >= 0)  chk("lit_fire", longint'(iss_fire), longint'(e_fire));
        if (e_sb >= 0)    chk("lit_src_busy", longint'(src_busy), longint'(e_sb));
        @(posedge clk);
        if (rst) begin
            foreach (ready_at[r]) ready_at[r] = 0;
            m_stall_cnt = 0;
        end else begin
            if (iss_valid && st && !flush && m_stall_cnt != 64'hFFFF_FFFF) m_stall_cnt++;
            if (flush) begin
                foreach (ready_at[r]) ready_at[r] = 0;
            end else begin
                if (wb_valid && wb_rd_num != 0 && ready_at[wb_rd_num] == INF)
                    ready_at[wb_rd_num] = cyc + 1;
                if (fi && iss_has_rd && iss_rd_num != 0 && iss_lat != 0)
                    ready_at[iss_rd_num] = (iss_lat == '1) ? INF : cyc + longint'(iss_lat);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        foreach (ready_at[r]) ready_at[r] = 0;
        rst = 1'b1;
        idle();
        @(negedge clk);
        step(1, 0, 0);
        set_iss(1, 1, 5, 1, 3, 1, 2);
        step(1, 0, 0);
        rst = 1'b0;
        idle();
        step(0, 0, 0);

        // back-to-back forward with lat=1
        set_iss(1, 1, 5, 1, 0, 0, 0); step(0, 1, 0);
        set_iss(1, 0, 0, 0, 1, 5, 0); step(0, 1, 0);
        idle(); step();

        // load-use: one bubble
        set_iss(1, 1, 7, 2, 0, 0, 0); step(0, 1, 0);
        set_iss(1, 0, 0, 0, 2, 0, 7); step(1, 0, 2);
        step(0, 1, 0);
        idle(); step();

        // variable latency cleared by writeback
        set_iss(1, 1, 3, 7, 0, 0, 0); step(0, 1, 0);
        set_iss(1, 0, 0, 0, 1, 3, 0);
        for (int k = 0; k < 10; k++) step(1, 0, 1);
        wb_valid = 1'b1; wb_rd_num = 5'd3; step(1, 0, 1);
        wb_valid = 1'b0; step(0, 1, 0);
        idle(); step();

        // WAW and same-cycle priority
        set_iss(1, 1, 9, 7, 0, 0, 0); step(0, 1, 0);
        set_iss(1, 1, 9, 2, 0, 0, 0); step(1, 0, 0);
        wb_valid = 1'b1; wb_rd_num = 5'd9; step(1, 0, 0);
        wb_valid = 1'b0; step(0, 1, 0);
        idle(); step();
        set_iss(1, 1, 9, 2, 0, 0, 0); wb_valid = 1'b1; wb_rd_num = 5'd9; step(0, 1, 0);
        idle(); set_iss(1, 0, 0, 0, 1, 9, 0); step(1, 0, 1);
        step(0, 1, 0);
        idle(); step();

        // zero register and flush
        set_iss(1, 1, 0, 2, 0, 0, 0); step(0, 1, 0);
        set_iss(1, 0, 0, 0, 1, 0, 0); step(0, 1, 0);
        set_iss(1, 1, 4, 7, 0, 0, 0); step(0, 1, 0);
        set_iss(1, 1, 6, 3, 0, 0, 0); step(0, 1, 0);
        set_iss(1, 0, 0, 0, 0, 0, 0); flush = 1'b1; step(0, 0, 0);
        flush = 1'b0; set_iss(1, 0, 0, 0, 3, 4, 6); step(0, 1, 0);
        idle(); step();

        // reset mid-countdown discards pending entries
        set_iss(1, 1, 10, 7, 0, 0, 0); step(0, 1, 0);
        set_iss(1, 1, 11, 5, 0, 0, 0); step(0, 1, 0);
        rst = 1'b1; set_iss(1, 0, 0, 0, 1, 10, 0); step(1, 0, 0);
        rst = 1'b0; set_iss(1, 0, 0, 0, 3, 10, 11); step(0, 1, 0);

        set_iss(1, 1, 12, 7, 0, 0, 0); step(0, 1, 0);
        set_iss(1, 0, 0, 0, 1, 12, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 1);
        idle();
`ifdef HZD_STALL_CNT_EN
        #1 chk("lit_stall_cycles_3", longint'(stall_cycles), 3);
`endif
        rst = 1'b1; step(1, 0, 0);
        rst = 1'b0;
`ifdef HZD_STALL_CNT_EN
        #1 chk("lit_stall_cycles_rst", longint'(stall_cycles), 0);
`endif
        step(0, 0, 0);

        // randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            set_iss($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                    $urandom_range(0, 7), $urandom_range(0, 7));
            wb_valid  = $urandom_range(0, 99) < 20;
            wb_rd_num = RW'($urandom_range(0, 7));
            flush     = $urandom_range(0, 99) < 2;
            rst       = $urandom_range(0, 199) < 1;
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
